quarter_wave_nco: RTL and testbench
===================================

# quarter_wave_nco

Numerically controlled oscillator that drives the 256-entry quarter-wave cosine table. It reads the table's 8-bit signed data and rebuilds full-wave signed cosine and sine samples using quadrant symmetry. It owns the phase accumulator and the table's address port, time-multiplexing one table port for the cos and sin fetches. Samples go to the mixer/modulator through a valid/ready handshake.

## Interface
- PHASE_W, 16, accumulator width; must be ≥ 10; the top 10 bits form the table phase.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; a new sample starts only while high.
- fcw  in  PHASE_W  frequency control word, unsigned, added to the accumulator once per started sample.
- phase_off  in  PHASE_W  phase offset, added mod 2^PHASE_W to the accumulator when a sample's phase is latched.
- sync  in  1  accumulator clear (see Operation).
- lut_addr  out  16  table address; bits [15:8] always 0.
- lut_data  in  8  signed table value for lut_addr, combinational same cycle, range 0..127.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts sample.
- cos_out  out  8  signed cosine, −127..127.
- sin_out  out  8  signed sine, −127..127.

## Operation
- Registers:
  - acc[PHASE_W], the accumulator.
  - ph_r[9:0], the latched phase.
  - cos_r and sin_r, which drive cos_out and sin_out.
  - state.
- Phase decode: q = ph_r[9:8], k = ph_r[7:0], T[i] = lut_data when lut_addr = i.
- Table mapping per quadrant; the 255−k mirror is a deliberate half-step approximation:
  - q0: cos = T[k], sin = T[255−k].
  - q1: cos = −T[255−k], sin = T[k].
  - q2: cos = −T[k], sin = −T[255−k].
  - q3: cos = T[255−k], sin = −T[k].
- Negation is 8-bit two's complement; no overflow is possible.
- FSM states: IDLE, FETCH_C, FETCH_S, HOLD.
  - IDLE: if en, latch and go to FETCH_C; otherwise stay.
  - FETCH_C: lut_addr = cos index; capture signed value into cos_r; go to FETCH_S.
  - FETCH_S: lut_addr = sin index; capture into sin_r; go to HOLD.
  - HOLD: out_valid = 1. On out_ready, go to FETCH_C with a latch if en; otherwise go to IDLE. If out_ready is low, stay.
- Latch action:
  - ph_r = (acc + phase_off)[PHASE_W−1 -: 10].
  - acc ← acc + fcw, wrapping mod 2^PHASE_W.
- sync:
  - Asserted in a latching cycle: ph_r uses phase_off alone (acc treated as 0), and acc ← fcw.
  - Asserted in any other cycle: acc ← 0.
  - sync never disturbs ph_r or a fetch already in progress.
- lut_addr is {8'b0, index} in FETCH_C and FETCH_S, and 0 in IDLE and HOLD.
- fcw and phase_off are sampled only on the latch edge. Changes at any other time take effect on the next sample.
- en deasserted mid-fetch: the current sample still completes and is presented.

## Timing
- Reset values: state IDLE, acc 0, ph_r 0, cos_out 0, sin_out 0, out_valid 0, lut_addr 0.
- Reset mid-fetch or in HOLD abandons the sample; the next cycle shows reset values.
- Latency, with en high in IDLE at cycle 0:
  - cycle 1: FETCH_C.
  - cycle 2: FETCH_S.
  - cycle 3: out_valid = 1 with the new cos_out and sin_out.
- Throughput: with out_ready and en held high, one sample every 3 cycles. out_valid is high one cycle in three.
- Handshake:
  - Transfer occurs on a cycle with out_valid and out_ready both high.
  - While out_valid is high and out_ready is low, cos_out, sin_out and acc hold stable.
  - out_valid never drops without a transfer, except on rst.
- cos_out and sin_out change only on the FETCH_C and FETCH_S edges. They keep the last sample's values while in IDLE.

## Test plan
- Quadrant corners, fcw = 0, phase_off swept over 0x0000/0x4000/0x8000/0xC000, one sample each. Required (cos, sin): (127, 0), (0, 127), (−127, 0), (0, −127). lut_addr = 0 then 255 (cos, sin) for phase 0.
- phase_off = 0x2000 → cos_out = 89, sin_out = 90; lut_addr sequence 128, 127.
- fcw = 0x0040, out_ready = 1, en = 1 for 30 cycles → out_valid every 3rd cycle. k increments 0, 1, 2, …; first cos values are 127, 127, 127.
- Wrap: acc preset by fcw = 0xFFC0 for one sample, then fcw = 0x0040 → acc = 0x0000 after the second latch. The next sample equals the phase-0 sample.
- Backpressure: out_ready = 0 for 5 cycles in HOLD → out_valid stays high, outputs and acc unchanged, lut_addr = 0. Releasing ready transfers exactly one sample.
- Events:
  - sync asserted in FETCH_S → the current sample is unaffected, and the next sample's phase = phase_off.
  - rst asserted in FETCH_C → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/quarter_wave_nco.sv
// Quarter-wave NCO: phase accumulator plus one shared table port, rebuilding signed cos/sin.
// Latency: 3 cycles from a latch (IDLE+en) to out_valid; one sample every 3 cycles when streaming.
// Backpressure: HOLD keeps out_valid, samples and accumulator stable until out_ready.
module quarter_wave_nco #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic               sync,
  output logic [15:0]        lut_addr,
  input  logic [7:0]         lut_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         cos_out,
  output logic [7:0]         sin_out
);

  typedef enum logic [1:0] {IDLE, FETCH_C, FETCH_S, HOLD} state_t;

  state_t             state_q;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] acc_base;
  logic [9:0]         ph_q, ph_d;
  logic [7:0]         cos_q, sin_q;
  logic [15:0]        lut_addr_q;
  logic               out_valid_q;
  logic               latch;
  logic [7:0]         lut_neg;

  // Odd quadrants read the table mirrored (255-k) for cos, straight for sin.
  function automatic logic [7:0] cos_index(input logic [9:0] p);
    return p[8] ? ~p[7:0] : p[7:0];
  endfunction

  function automatic logic [7:0] sin_index(input logic [9:0] p);
    return p[8] ? p[7:0] : ~p[7:0];
  endfunction

  // A sample starts from IDLE, or from HOLD on the same edge its predecessor transfers.
  assign latch   = en && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign lut_neg = -lut_data;

  // Accumulator next state and latched phase; sync zeroes the accumulator seen by this edge.
  always_comb begin
    acc_base = sync ? '0 : acc_q;
    ph_d     = 10'((acc_base + phase_off) >> (PHASE_W - 10));
    acc_d    = latch ? (acc_base + fcw) : acc_base;
  end

  // Sequencer: latch phase, fetch cos then sin through the shared port, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ph_q        <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      lut_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          if (latch) begin
            ph_q       <= ph_d;
            lut_addr_q <= {8'b0, cos_index(ph_d)};
            state_q    <= FETCH_C;
          end
        end
        FETCH_C: begin
          // cos is negated in quadrants 1 and 2
          cos_q      <= (ph_q[9] ^ ph_q[8]) ? lut_neg : lut_data;
          lut_addr_q <= {8'b0, sin_index(ph_q)};
          state_q    <= FETCH_S;
        end
        FETCH_S: begin
          // sin is negated in quadrants 2 and 3
          sin_q       <= ph_q[9] ? lut_neg : lut_data;
          lut_addr_q  <= '0;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (latch) begin
              ph_q       <= ph_d;
              lut_addr_q <= {8'b0, cos_index(ph_d)};
              state_q    <= FETCH_C;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lut_addr  = lut_addr_q;
  assign out_valid = out_valid_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule

// File: tb/tb_quarter_wave_nco.sv
// Bench for quarter_wave_nco: models the quarter-wave table, scoreboards every transferred sample.
// Each scenario pushes its expected samples; a negedge monitor pops on every transfer.
// Backpressure, sync, wrap and reset-abandon scenarios check handshake and accumulator effects.
module tb_quarter_wave_nco;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] fcw;
  logic [15:0] phase_off;
  logic        sync;
  logic [15:0] lut_addr;
  logic [7:0]  lut_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  cos_out;
  logic [7:0]  sin_out;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] s;
  } samp_t;

  samp_t      sb[$];
  logic [7:0] tbl[256];
  int         n_tests = 0;
  int         n_fail  = 0;

  quarter_wave_nco #(.PHASE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fcw       (fcw),
    .phase_off (phase_off),
    .sync      (sync),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational table read, as the real ROM behaves
  assign lut_data = tbl[lut_addr[7:0]];

  // Full-wave reference built straight from the quadrant table
  function automatic samp_t model(input logic [9:0] ph);
    samp_t      r;
    logic [7:0] k;
    logic [7:0] km;
    k  = ph[7:0];
    km = 8'd255 - k;
    case (ph[9:8])
      2'd0: begin r.c = tbl[k];       r.s = tbl[km];      end
      2'd1: begin r.c = -tbl[km];     r.s = tbl[k];       end
      2'd2: begin r.c = -tbl[k];      r.s = -tbl[km];     end
      default: begin r.c = tbl[km];   r.s = -tbl[k];      end
    endcase
    return r;
  endfunction

  function automatic samp_t mk(input int c, input int s);
    samp_t r;
    r.c = 8'(c);
    r.s = 8'(s);
    return r;
  endfunction

  // Transfer monitor: every accepted sample must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sample_unexpected: got cos=%0d sin=%0d, expected no transfer",
                 $signed(cos_out), $signed(sin_out));
      end else begin
        samp_t e;
        e = sb.pop_front();
        if ({cos_out, sin_out} !== {e.c, e.s}) begin
          n_fail++;
          $display("FAIL sample_value: got cos=%0d sin=%0d, expected cos=%0d sin=%0d",
                   $signed(cos_out), $signed(sin_out), $signed(e.c), $signed(e.s));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One isolated sample from IDLE; checks latency and both fetch addresses
  task automatic run_one(input logic [15:0] off, input logic [15:0] f,
                         input logic [15:0] ca, input logic [15:0] sa, input samp_t e);
    phase_off = off;
    fcw       = f;
    en        = 1'b1;
    out_ready = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    chk("addr_cos", lut_addr, ca);
    chk("valid_c1", {15'b0, out_valid}, 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("addr_sin", lut_addr, sa);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_c3", {15'b0, out_valid}, 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; fcw = '0; phase_off = '0; sync = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {15'b0, out_valid}, 16'd0);
    chk("rst_cos", {8'b0, cos_out}, 16'd0);
    chk("rst_sin", {8'b0, sin_out}, 16'd0);
    chk("rst_addr", lut_addr, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_corners();
    do_reset();
    run_one(16'h0000, 16'h0, 16'd0,   16'd255, mk(127, 0));
    run_one(16'h4000, 16'h0, 16'd255, 16'd0,   mk(0, 127));
    run_one(16'h8000, 16'h0, 16'd0,   16'd255, mk(-127, 0));
    run_one(16'hC000, 16'h0, 16'd255, 16'd0,   mk(0, -127));
    run_one(16'h2000, 16'h0, 16'd128, 16'd127, mk(89, 90));
  endtask

  task automatic test_stream();
    do_reset();
    fcw = 16'h0040; phase_off = 16'h0; out_ready = 1'b1;
    sb.push_back(mk(127, tbl[255]));
    sb.push_back(mk(127, tbl[254]));
    sb.push_back(mk(127, tbl[253]));
    for (int n = 3; n < 10; n++) sb.push_back(model(10'(n)));
    en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 30) en = 1'b0;
      @(negedge clk);
      chk($sformatf("stream_valid_%0d", i), {15'b0, out_valid}, {15'b0, (i % 3 == 0)});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_reset();
    run_one(16'h0, 16'hFFC0, 16'd0, 16'd255, mk(127, 0));
    run_one(16'h0, 16'h0040, 16'd0, 16'd255, model(10'h3FF));
    run_one(16'h0, 16'h0000, 16'd0, 16'd255, mk(127, 0));
  endtask

  task automatic test_backpressure();
    do_reset();
    phase_off = 16'h2000; fcw = 16'h0040; out_ready = 1'b0; en = 1'b1;
    sb.push_back(mk(89, 90));
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {15'b0, out_valid}, 16'd1);
      chk("bp_cos", {8'b0, cos_out}, 16'd89);
      chk("bp_sin", {8'b0, sin_out}, 16'd90);
      chk("bp_addr", lut_addr, 16'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; en = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_valid", {15'b0, out_valid}, 16'd0);
    @(posedge clk); #1;
    // accumulator advanced exactly once: 0x0040 + 0x2000 -> phase 129
    run_one(16'h2000, 16'h0, 16'd129, 16'd126, model(10'd129));
  endtask

  task automatic test_sync();
    do_reset();
    phase_off = 16'h4000; fcw = 16'h1000; out_ready = 1'b1; en = 1'b1;
    sb.push_back(mk(0, 127));
    sb.push_back(mk(0, 127));
    sb.push_back(model(10'h140));
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      sync = (i == 2);
      if (i == 9) en = 1'b0;
      @(negedge clk);
      chk("sync_valid", {15'b0, out_valid}, {15'b0, (i % 3 == 0)});
    end
    sync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    run_one(16'h2000, 16'h0, 16'd128, 16'd127, mk(89, 90));
    phase_off = 16'h0; fcw = 16'h0; en = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cos", {8'b0, cos_out}, 16'd0);
    chk("mid_rst_sin", {8'b0, sin_out}, 16'd0);
    chk("mid_rst_valid", {15'b0, out_valid}, 16'd0);
    chk("mid_rst_addr", lut_addr, 16'd0);
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_idle", {15'b0, out_valid}, 16'd0);
    end
    @(posedge clk); #1;
    run_one(16'h8000, 16'h0, 16'd0, 16'd255, mk(-127, 0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      tbl[i] = 8'($rtoi($floor(127.5 * $cos(3.14159265358979 / 2.0 * (real'(i) + 0.5) / 256.0))));
    test_reset();
    test_corners();
    test_stream();
    test_wrap();
    test_backpressure();
    test_sync();
    test_reset_midfetch();
    repeat (2) @(posedge clk);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
